// File: rtl/clic_arb_seq.sv
// Sequential wired-OR interrupt arbiter: pending/enable/threshold filtering, bit-serial
// priority-then-index resolution, and a valid/ready presentation of the winner.

module clic_arb_seq_chk #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic         in_present,
  input logic         in_idle,
  input logic [N-1:0] contender
);

  a_single_winner: assert property (@(posedge clk) disable iff (!rst_n)
    in_present |-> $onehot(contender));

  a_nonempty_round: assert property (@(posedge clk) disable iff (!rst_n)
    !in_idle |-> (contender != '0));

endmodule

module clic_arb_seq #(
  parameter int NR_INDEX_BITS = 3,
  parameter int NR_PRIO_BITS  = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [(2**NR_INDEX_BITS)-1:0]              irq_set,
  input  logic [(2**NR_INDEX_BITS)-1:0]              irq_en,
  input  logic [(2**NR_INDEX_BITS)*NR_PRIO_BITS-1:0] prio,
  input  logic [NR_PRIO_BITS-1:0]                    threshold,
  output logic                                      irq_valid,
  output logic [NR_INDEX_BITS-1:0]                   irq_index,
  output logic [NR_PRIO_BITS-1:0]                    irq_prio,
  input  logic                                      irq_ready,
  output logic                                      busy,
  output logic [(2**NR_INDEX_BITS)-1:0]              pending
);

  localparam int N    = 2**NR_INDEX_BITS;
  localparam int P    = NR_PRIO_BITS;
  localparam int I    = NR_INDEX_BITS;
  localparam int MAXB = (P > I) ? P : I;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIO    = 2'd1,
    ST_IDX     = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    contender_q, contender_d;
  logic [N*P-1:0]  snap_prio_q, snap_prio_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic            irq_valid_q, irq_valid_d;
  logic [I-1:0]    irq_index_q, irq_index_d;
  logic [P-1:0]    irq_prio_q, irq_prio_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    elig_s;
  logic [N-1:0]    sel_s;
  logic [N-1:0]    clr_s;
  logic [P-1:0]    pmask_s;
  logic [I-1:0]    imask_s;
  logic            or_s;

  // Eligibility of each source from live pending, enable, priority and threshold.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N; i++) begin
      elig_s[i] = pending_q[i] & irq_en[i] & (prio[i*P +: P] > threshold);
    end
  end

  // Wired-OR bus for the bit under arbitration: snapshot priority bit or index bit.
  always_comb begin
    pmask_s = NR_PRIO_BITS'(1) << bit_q;
    imask_s = NR_INDEX_BITS'(1) << bit_q;
    sel_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q == ST_PRIO) begin
        sel_s[i] = |(snap_prio_q[i*P +: P] & pmask_s);
      end else begin
        sel_s[i] = |(NR_INDEX_BITS'(i) & imask_s);
      end
    end
    or_s = |(contender_q & sel_s);
  end

  // Pending update; a same-cycle set overrides the acceptance clear.
  always_comb begin
    clr_s = '0;
    if ((state_q == ST_PRESENT) && irq_ready) begin
      clr_s[irq_index_q] = 1'b1;
    end else begin
      clr_s = '0;
    end
    pending_d = (pending_q & ~clr_s) | irq_set;
  end

  // Arbitration FSM next-state and datapath.
  always_comb begin
    state_d     = state_q;
    contender_d = contender_q;
    snap_prio_d = snap_prio_q;
    bit_d       = bit_q;
    irq_valid_d = irq_valid_q;
    irq_index_d = irq_index_q;
    irq_prio_d  = irq_prio_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          state_d     = ST_PRIO;
          contender_d = elig_s;
          snap_prio_d = prio;
          bit_d       = CW'(P - 1);
          irq_index_d = '0;
          irq_prio_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIO: begin
        // The winner's priority is exactly the sequence of wired-OR levels seen.
        if (or_s) begin
          contender_d = contender_q & sel_s;
          irq_prio_d  = irq_prio_q | pmask_s;
        end else begin
          contender_d = contender_q;
        end
        if (bit_q == CW'(0)) begin
          state_d = ST_IDX;
          bit_d   = CW'(I - 1);
        end else begin
          bit_d = bit_q - CW'(1);
        end
      end
      ST_IDX: begin
        if (or_s) begin
          contender_d = contender_q & sel_s;
          irq_index_d = irq_index_q | imask_s;
        end else begin
          contender_d = contender_q;
        end
        if (bit_q == CW'(0)) begin
          state_d     = ST_PRESENT;
          irq_valid_d = 1'b1;
        end else begin
          bit_d = bit_q - CW'(1);
        end
      end
      ST_PRESENT: begin
        if (irq_ready) begin
          state_d     = ST_IDLE;
          irq_valid_d = 1'b0;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      contender_q <= '0;
      snap_prio_q <= '0;
      bit_q       <= '0;
      irq_valid_q <= 1'b0;
      irq_index_q <= '0;
      irq_prio_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      contender_q <= contender_d;
      snap_prio_q <= snap_prio_d;
      bit_q       <= bit_d;
      irq_valid_q <= irq_valid_d;
      irq_index_q <= irq_index_d;
      irq_prio_q  <= irq_prio_d;
      busy_q      <= busy_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_index = irq_index_q;
  assign irq_prio  = irq_prio_q;
  assign busy      = busy_q;
  assign pending   = pending_q;

  clic_arb_seq_chk #(.N(N)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_present (state_q == ST_PRESENT),
    .in_idle    (state_q == ST_IDLE),
    .contender  (contender_q)
  );

endmodule

// File: tb/tb_clic_arb_seq.sv
// Bench for clic_arb_seq: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level reference model.

module tb_clic_arb_seq;

  localparam int I = 3;
  localparam int P = 3;
  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   irq_set;
  logic [N-1:0]   irq_en;
  logic [N*P-1:0] prio;
  logic [P-1:0]   threshold;
  logic           irq_valid;
  logic [I-1:0]   irq_index;
  logic [P-1:0]   irq_prio;
  logic           irq_ready;
  logic           busy;
  logic [N-1:0]   pending;

  int checks;
  int failures;

  clic_arb_seq #(.NR_INDEX_BITS(I), .NR_PRIO_BITS(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_set   (irq_set),
    .irq_en    (irq_en),
    .prio      (prio),
    .threshold (threshold),
    .irq_valid (irq_valid),
    .irq_index (irq_index),
    .irq_prio  (irq_prio),
    .irq_ready (irq_ready),
    .busy      (busy),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a round is "snapshot winner, then P+I cycles, then present".
  logic [N-1:0] m_pend;
  logic [N-1:0] m_clr;
  bit           m_busy;
  bit           m_valid;
  int           m_timer;
  int           m_idx;
  int           m_prio;
  int           best;
  int           bp;
  int           pv;

  initial begin
    m_pend = '0; m_busy = 1'b0; m_valid = 1'b0; m_timer = 0; m_idx = 0; m_prio = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pend = '0; m_busy = 1'b0; m_valid = 1'b0; m_timer = 0; m_idx = 0; m_prio = 0;
      end else begin
        m_clr = '0;
        if (m_valid && irq_ready) m_clr[m_idx] = 1'b1;
        if (!m_busy) begin
          best = -1;
          bp   = -1;
          for (int i = 0; i < N; i++) begin
            pv = int'(prio[i*P +: P]);
            if (m_pend[i] && irq_en[i] && (pv > int'(threshold)) && (pv >= bp)) begin
              best = i;
              bp   = pv;
            end
          end
          if (best >= 0) begin
            m_busy  = 1'b1;
            m_timer = P + I;
            m_idx   = best;
            m_prio  = bp;
          end
        end else if (m_timer > 0) begin
          m_timer--;
          if (m_timer == 0) m_valid = 1'b1;
        end else if (irq_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
        m_pend = (m_pend & ~m_clr) | irq_set;
      end
      #1;
      chk("m_valid", irq_valid, m_valid);
      chk("m_busy", busy, m_busy);
      chk("m_pending", pending, m_pend);
      if (m_valid) begin
        chk("m_index", irq_index, m_idx);
        chk("m_prio", irq_prio, m_prio);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_prio(input int i, input int v);
    prio[i*P +: P] = P'(v);
  endtask

  task automatic wait_valid(input string nm, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq_valid && (n < max));
    if (!irq_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no irq_valid expected irq_valid within %0d cycles", nm, max);
    end
  endtask

  task automatic accept(input string nm, input int idx);
    logic [N-1:0] p;
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    p = pending;
    chk({nm, "_valid_drop"}, irq_valid, 0);
    chk({nm, "_pend_clr"}, p[idx], 0);
  endtask

  int n;
  int exp_order[3];
  logic [N-1:0] pq;

  initial begin
    rst_n = 1'b0; irq_set = '0; irq_en = '0; prio = '0; threshold = '0; irq_ready = 1'b0;
    checks = 0; failures = 0;
    tick(); tick();
    chk("rst_valid", irq_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_index", irq_index, 0);
    chk("rst_prio", irq_prio, 0);
    rst_n = 1'b1;
    tick();

    // T1 single source latency and acceptance
    irq_en = 8'hFF;
    set_prio(5, 4);
    irq_set = 8'h20;
    tick();
    irq_set = 8'h00;
    wait_valid("t1", 50, n);
    chk("t1_latency", n, 7);
    chk("t1_index", irq_index, 5);
    chk("t1_prio", irq_prio, 4);
    accept("t1", 5);

    // T2 priority then highest-index tie break, ready held high
    set_prio(1, 6); set_prio(2, 6); set_prio(6, 3);
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 6;
    irq_ready = 1'b1;
    irq_set = 8'h46;
    tick();
    irq_set = 8'h00;
    for (int g = 0; g < 3; g++) begin
      wait_valid("t2", 50, n);
      chk("t2_gap", n, 7);
      chk("t2_order", irq_index, exp_order[g]);
      tick();
      chk("t2_valid_drop", irq_valid, 0);
    end
    irq_ready = 1'b0;
    chk("t2_pending_empty", pending, 0);

    // T3 threshold blocks equal priority
    threshold = 3'd5;
    set_prio(3, 5);
    irq_set = 8'h08;
    tick();
    irq_set = 8'h00;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t3_no_valid", irq_valid, 0);
      chk("t3_idle", busy, 0);
    end
    set_prio(3, 6);
    wait_valid("t3", 50, n);
    chk("t3_latency", n, 7);
    chk("t3_index", irq_index, 3);
    accept("t3", 3);
    threshold = 3'd0;

    // T4 enable gating and snapshot of enable
    irq_en = 8'hEF;
    set_prio(4, 2);
    irq_set = 8'h10;
    tick();
    irq_set = 8'h00;
    repeat (5) tick();
    chk("t4_idle", busy, 0);
    irq_en = 8'hFF;
    tick();
    chk("t4_round_start", busy, 1);
    tick();
    irq_en = 8'hEF;
    wait_valid("t4", 50, n);
    chk("t4_index", irq_index, 4);
    chk("t4_prio", irq_prio, 2);
    accept("t4", 4);
    irq_en = 8'hFF;

    // T5a set and accept collide on the same source
    set_prio(2, 3);
    irq_set = 8'h04;
    tick();
    irq_set = 8'h00;
    wait_valid("t5a", 50, n);
    chk("t5a_index", irq_index, 2);
    irq_ready = 1'b1;
    irq_set = 8'h04;
    tick();
    irq_ready = 1'b0;
    irq_set = 8'h00;
    pq = pending;
    chk("t5a_pend_kept", pq[2], 1);
    chk("t5a_valid_drop", irq_valid, 0);
    wait_valid("t5a_re", 50, n);
    chk("t5a_re_latency", n, 7);
    chk("t5a_re_index", irq_index, 2);
    accept("t5a", 2);

    // T5b higher priority arrives during the index phase of a round
    set_prio(0, 2); set_prio(7, 7);
    irq_set = 8'h01;
    tick();
    irq_set = 8'h00;
    repeat (5) tick();
    irq_set = 8'h80;
    tick();
    irq_set = 8'h00;
    irq_ready = 1'b1;
    wait_valid("t5b_first", 50, n);
    chk("t5b_first", irq_index, 0);
    tick();
    wait_valid("t5b_second", 50, n);
    chk("t5b_second", irq_index, 7);
    chk("t5b_second_prio", irq_prio, 7);
    tick();
    irq_ready = 1'b0;
    chk("t5b_pending_empty", pending, 0);

    // T6 reset in the middle of priority resolution
    set_prio(1, 5);
    irq_set = 8'h02;
    tick();
    irq_set = 8'h00;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", irq_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pending", pending, 0);
    chk("t6_index", irq_index, 0);
    chk("t6_prio", irq_prio, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_stay_idle", busy, 0);
    end
    irq_set = 8'h02;
    tick();
    irq_set = 8'h00;
    wait_valid("t6", 50, n);
    chk("t6_latency", n, 7);
    chk("t6_index", irq_index, 1);
    accept("t6", 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      irq_set = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      if ($urandom_range(0, 15) == 0) irq_en = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 7) == 0) prio = (N*P)'($urandom);
      if ($urandom_range(0, 31) == 0) threshold = P'($urandom_range(0, 3));
      irq_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst_n = 1'b1;
    irq_set = '0;
    irq_ready = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
